// File: rtl/vx_reg_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : vx_reg_scoreboard_pkg
//  Purpose  : Shared machine-wide definitions for the register scoreboard:
//             warp/register counts and the index-width helper used to size
//             every warp-id and register-index port.
//  Revision : 1.0  initial release
// ============================================================================
package vx_reg_scoreboard_pkg;

    // Machine-wide defaults: 32 integer + 32 FP registers per warp.
    localparam int VX_NUM_WARPS = 4;
    localparam int VX_NUM_REGS  = 64;

    // Index width for a table of n entries; never collapses to zero bits so
    // a single-warp build still has a legal 1-bit warp-id port.
    function automatic int vx_idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int VX_NW_BITS = vx_idx_bits(VX_NUM_WARPS);
    localparam int VX_NR_BITS = vx_idx_bits(VX_NUM_REGS);

endpackage : vx_reg_scoreboard_pkg
`default_nettype wire

// File: rtl/vx_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : vx_reg_scoreboard
//  Purpose  : Per-warp register in-use tracking between the instruction
//             buffer and dispatch. Blocks RAW/WAW hazards, releases
//             reservations on the last writeback packet (with same-cycle
//             bypass), and flags a sticky deadlock on long hazard stalls.
//  Ports    :
//    clk, reset                  clock, synchronous active-high reset
//    in_valid/in_ready           decoded instruction handshake (ibuffer side)
//    in_wid, in_wb               issuing warp, instruction writes rd
//    in_rd/in_rs1/in_rs2/in_rs3  destination / source register indices
//    in_data -> out_data         opaque payload, combinational pass-through
//    out_valid/out_ready         dispatch handshake
//    wb_valid/wb_ready           writeback stream handshake
//    wb_wid, wb_rd, wb_eop       writeback warp, register, last packet
//    deadlock                    sticky stall-timeout flag
//  Revision : 1.0  initial release
// ============================================================================
module vx_reg_scoreboard
    import vx_reg_scoreboard_pkg::*;
#(
    parameter  int NUM_WARPS     = VX_NUM_WARPS,
    parameter  int NUM_REGS      = VX_NUM_REGS,
    parameter  int DATAW         = 64,
    parameter  int STALL_TIMEOUT = 65535,
    localparam int NW_BITS       = vx_idx_bits(NUM_WARPS),
    localparam int NR_BITS       = vx_idx_bits(NUM_REGS)
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               in_valid,
    input  logic [NW_BITS-1:0] in_wid,
    input  logic               in_wb,
    input  logic [NR_BITS-1:0] in_rd,
    input  logic [NR_BITS-1:0] in_rs1,
    input  logic [NR_BITS-1:0] in_rs2,
    input  logic [NR_BITS-1:0] in_rs3,
    input  logic [DATAW-1:0]   in_data,
    output logic               in_ready,

    output logic               out_valid,
    output logic [DATAW-1:0]   out_data,
    input  logic               out_ready,

    input  logic               wb_valid,
    input  logic               wb_ready,
    input  logic [NW_BITS-1:0] wb_wid,
    input  logic [NR_BITS-1:0] wb_rd,
    input  logic               wb_eop,

    output logic               deadlock
);

    localparam int              CNT_W     = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_TIMEOUT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] inuse_q, inuse_d;
    logic [CNT_W-1:0]                   stall_cnt_q, stall_cnt_d;
    logic                               deadlock_q, deadlock_d;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic release_fire;
    logic set_fire;
    logic rd_busy, rs1_busy, rs2_busy, rs3_busy;
    logic hazard;

    // Only the last packet of a multi-packet writeback frees the register.
    assign release_fire = wb_valid & wb_ready & wb_eop;

    // A reservation being released this very cycle is treated as already
    // free, so a dependent instruction can issue with zero bubble.
    // Register 0 is hard-wired and never blocks anything.
    function automatic logic reg_busy(input logic [NR_BITS-1:0] r);
        logic released_now;
        released_now = release_fire && (wb_wid == in_wid) && (wb_rd == r);
        return (r != '0) && inuse_q[in_wid][r] && !released_now;
    endfunction

    assign rd_busy  = reg_busy(in_rd);
    assign rs1_busy = reg_busy(in_rs1);
    assign rs2_busy = reg_busy(in_rs2);
    assign rs3_busy = reg_busy(in_rs3);

    assign hazard    = in_valid & (rd_busy | rs1_busy | rs2_busy | rs3_busy);

    assign out_valid = in_valid & ~hazard;
    assign in_ready  = out_ready & ~hazard;
    assign out_data  = in_data;

    assign set_fire  = in_valid & in_ready & in_wb & (in_rd != '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        inuse_d = inuse_q;
        // Release applied first so a same-cycle set of the same bit wins.
        if (release_fire) begin
            inuse_d[wb_wid][wb_rd] = 1'b0;
        end
        if (set_fire) begin
            inuse_d[in_wid][in_rd] = 1'b1;
        end
        for (int w = 0; w < NUM_WARPS; w++) begin
            inuse_d[w][0] = 1'b0;
        end
    end

    // Counts consecutive hazard-stalled cycles only; plain back-pressure
    // (out_ready low without a hazard) leaves the counter at zero.
    always_comb begin
        stall_cnt_d = '0;
        if (hazard) begin
            stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q
                                                     : stall_cnt_q + CNT_W'(1);
        end
    end

    assign deadlock_d = deadlock_q | (stall_cnt_q == STALL_MAX);
    assign deadlock   = deadlock_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            inuse_q     <= '0;
            stall_cnt_q <= '0;
            deadlock_q  <= 1'b0;
        end else begin
            inuse_q     <= inuse_d;
            stall_cnt_q <= stall_cnt_d;
            deadlock_q  <= deadlock_d;
        end
    end

endmodule : vx_reg_scoreboard
`default_nettype wire

// File: tb/tb_vx_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vx_reg_scoreboard
//  Purpose  : Self-checking bench for vx_reg_scoreboard. Directed issue /
//             writeback scenarios; payloads of instructions expected to
//             dispatch are queued and matched against out_data on dispatch.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vx_reg_scoreboard;

    localparam int NW = 2;
    localparam int NR = 6;
    localparam int DW = 64;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [NW-1:0] in_wid;
    logic          in_wb;
    logic [NR-1:0] in_rd, in_rs1, in_rs2, in_rs3;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          wb_valid, wb_ready, wb_eop;
    logic [NW-1:0] wb_wid;
    logic [NR-1:0] wb_rd;
    logic          deadlock;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] sb_q[$];

    vx_reg_scoreboard #(
        .NUM_WARPS     (4),
        .NUM_REGS      (64),
        .DATAW         (DW),
        .STALL_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_wid    (in_wid),
        .in_wb     (in_wb),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rs3    (in_rs3),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_wid    (wb_wid),
        .wb_rd     (wb_rd),
        .wb_eop    (wb_eop),
        .deadlock  (deadlock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one instruction; if it should dispatch, queue its payload.
    task automatic issue(input logic v, input logic [NW-1:0] wid, input logic wb,
                         input logic [NR-1:0] rd, input logic [NR-1:0] rs1,
                         input logic [NR-1:0] rs2, input logic [NR-1:0] rs3,
                         input logic expect_go);
        in_valid = v;
        in_wid   = wid;
        in_wb    = wb;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rs3   = rs3;
        in_data  = {$urandom(), $urandom()};
        if (expect_go) sb_q.push_back(in_data);
    endtask

    task automatic wback(input logic v, input logic [NW-1:0] wid, input logic [NR-1:0] rd,
                         input logic eop, input logic rdy);
        wb_valid = v;
        wb_wid   = wid;
        wb_rd    = rd;
        wb_eop   = eop;
        wb_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Dispatch monitor: every accepted instruction must match the queue head.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) check("sb_underflow", 64'(sb_q.size()), 64'd1);
            else                  check("sb_data", out_data, sb_q.pop_front());
        end
    end

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        out_ready = 1'b1;
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        wback(0, 0, 0, 0, 1);
        next_cycle();

        // Outputs live during reset; the set attempted under reset is dropped.
        issue(1, 0, 1, 5, 0, 0, 0, 1);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 1);
        check("rst_deadlock", deadlock, 0);
        next_cycle();
        reset = 1'b0;
        issue(1, 0, 0, 0, 5, 0, 0, 1);
        @(negedge clk); check("rst_no_reserve", in_ready, 1);
        next_cycle();

        // RAW stall on warp 1, warp 2 unaffected, then bypassed release.
        issue(1, 1, 1, 5, 0, 0, 0, 1);
        @(negedge clk); check("w1_set_go", in_ready, 1);
        next_cycle();
        issue(1, 1, 0, 0, 5, 0, 0, 0);
        @(negedge clk); check("w1_raw_stall", in_ready, 0); check("w1_raw_ov", out_valid, 0);
        next_cycle();
        issue(1, 2, 0, 0, 5, 0, 0, 1);
        @(negedge clk); check("w2_indep", in_ready, 1);
        next_cycle();
        wback(1, 1, 5, 1, 1); issue(1, 1, 0, 0, 5, 0, 0, 1);
        @(negedge clk); check("w1_bypass", in_ready, 1);
        next_cycle();

        // rs2 bypass on same-cycle eop release.
        wback(0, 0, 0, 0, 1); issue(1, 0, 1, 7, 0, 0, 0, 1);
        next_cycle();
        wback(1, 0, 7, 1, 1); issue(1, 0, 0, 0, 0, 7, 0, 1);
        @(negedge clk); check("rs2_bypass", in_ready, 1);
        next_cycle();

        // Non-eop writeback keeps the reservation.
        wback(0, 0, 0, 0, 1); issue(1, 0, 1, 7, 0, 0, 0, 1);
        next_cycle();
        wback(1, 0, 7, 0, 1); issue(1, 0, 0, 0, 0, 0, 7, 0);
        @(negedge clk); check("noeop_stall", in_ready, 0);
        next_cycle();
        wback(1, 0, 7, 1, 1); issue(1, 0, 0, 0, 0, 0, 7, 1);
        @(negedge clk); check("eop_release", in_ready, 1);
        next_cycle();
        wback(0, 0, 0, 0, 1); issue(1, 0, 0, 0, 7, 0, 0, 1);
        @(negedge clk); check("after_release", in_ready, 1);
        next_cycle();

        // Writeback without wb_ready is not a release.
        issue(1, 2, 1, 9, 0, 0, 0, 1);
        next_cycle();
        wback(1, 2, 9, 1, 0); issue(1, 2, 0, 0, 9, 0, 0, 0);
        @(negedge clk); check("wb_not_ready", in_ready, 0);
        next_cycle();
        wback(0, 0, 0, 0, 1); issue(1, 2, 0, 0, 9, 0, 0, 0);
        @(negedge clk); check("still_held", in_ready, 0);
        next_cycle();
        wback(1, 2, 9, 1, 1); issue(1, 2, 0, 0, 9, 0, 0, 1);
        @(negedge clk); check("held_release", in_ready, 1);
        next_cycle();

        // Same-bit set and release: set wins.
        wback(0, 0, 0, 0, 1); issue(1, 0, 1, 3, 0, 0, 0, 1);
        next_cycle();
        wback(1, 0, 3, 1, 1); issue(1, 0, 1, 3, 0, 0, 0, 1);
        @(negedge clk); check("set_wins_go", in_ready, 1);
        next_cycle();
        wback(0, 0, 0, 0, 1); issue(1, 0, 0, 0, 3, 0, 0, 0);
        @(negedge clk); check("set_wins_held", in_ready, 0);
        next_cycle();
        wback(1, 0, 3, 1, 1); issue(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        // Different-bit set and release in one cycle both apply.
        wback(0, 0, 0, 0, 1); issue(1, 0, 1, 10, 0, 0, 0, 1);
        next_cycle();
        wback(1, 0, 10, 1, 1); issue(1, 0, 1, 11, 0, 0, 0, 1);
        @(negedge clk); check("diff_go", in_ready, 1);
        next_cycle();
        wback(0, 0, 0, 0, 1); issue(1, 0, 0, 0, 10, 0, 0, 1);
        @(negedge clk); check("diff_released", in_ready, 1);
        next_cycle();
        issue(1, 0, 0, 0, 0, 11, 0, 0);
        @(negedge clk); check("diff_set", in_ready, 0);
        next_cycle();
        wback(1, 0, 11, 1, 1); issue(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        // rd = 0 never reserves.
        wback(0, 0, 0, 0, 1);
        issue(1, 0, 1, 0, 0, 0, 0, 1);
        @(negedge clk); check("rd0_a", in_ready, 1);
        next_cycle();
        issue(1, 0, 1, 0, 0, 0, 0, 1);
        @(negedge clk); check("rd0_b", in_ready, 1);
        next_cycle();

        // Back-pressure: no set, no stall counting.
        out_ready = 1'b0;
        issue(1, 3, 1, 12, 0, 0, 0, 0);
        @(negedge clk); check("bp_ready", in_ready, 0); check("bp_valid", out_valid, 1);
        for (int i = 0; i < 11; i++) next_cycle();
        @(negedge clk); check("bp_no_deadlock", deadlock, 0);
        next_cycle();
        out_ready = 1'b1;
        issue(1, 3, 0, 0, 12, 0, 0, 1);
        @(negedge clk); check("bp_no_set", in_ready, 1);
        next_cycle();

        // Stall counter clears on a hazard-free cycle.
        issue(1, 0, 1, 20, 0, 0, 0, 1);
        next_cycle();
        issue(1, 0, 0, 0, 20, 0, 0, 0);
        for (int i = 0; i < 6; i++) next_cycle();
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        issue(1, 0, 0, 0, 20, 0, 0, 0);
        for (int i = 0; i < 6; i++) next_cycle();
        @(negedge clk); check("cnt_cleared", deadlock, 0);
        next_cycle();
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        // Nine hazard cycles with timeout 8: deadlock rises, then sticks.
        issue(1, 0, 0, 0, 20, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); check("dl_not_early", deadlock, 0);
            next_cycle();
        end
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("dl_set", deadlock, 1);
        for (int i = 0; i < 4; i++) next_cycle();
        @(negedge clk); check("dl_sticky", deadlock, 1);
        next_cycle();

        // Reset clears deadlock and discards the [0][20] reservation.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        issue(1, 0, 0, 0, 20, 0, 0, 1);
        @(negedge clk); check("dl_reset", deadlock, 0); check("rst_discard", in_ready, 1);
        next_cycle();
        wback(1, 0, 20, 1, 1); issue(1, 0, 0, 0, 0, 20, 0, 1);
        @(negedge clk); check("stale_wb_noop", in_ready, 1);
        next_cycle();
        wback(0, 0, 0, 0, 1); issue(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) next_cycle();

        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_vx_reg_scoreboard
`default_nettype wire

// File: doc/vx_reg_scoreboard.md
VX_REG_SCOREBOARD -- requirements
Module: vx_reg_scoreboard

Interface
REQ-001 Parameters: NUM_WARPS, default 4, warps tracked; NUM_REGS, default 64, architectural registers per warp (32 integer + 32 FP); DATAW, default 64, opaque issue payload width; STALL_TIMEOUT, default 65535, hazard-stall cycles before a deadlock is flagged.
REQ-002 Ports, one per line:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction from ibuffer
- in_wid  in  NW_BITS  issuing warp
- in_wb  in  1  instruction writes rd
- in_rd / in_rs1 / in_rs2 / in_rs3  in  NR_BITS each  dest/source register indices
- in_data  in  DATAW  payload passed through
- in_ready  out  1  instruction accepted
- out_valid  out  1  hazard-free instruction to dispatch
- out_data  out  DATAW  equals in_data
- out_ready  in  1  dispatch accepts
- wb_valid / wb_ready  in  1 each  writeback stream handshake
- wb_wid  in  NW_BITS  writeback warp
- wb_rd  in  NR_BITS  writeback register
- wb_eop  in  1  last writeback packet of the instruction
- deadlock  out  1  sticky stall-timeout flag

Function
REQ-003 State: one in-use bit per (warp, register), NUM_WARPS x NUM_REGS bits.
REQ-004 Release event: wb_valid && wb_ready && wb_eop clears bit [wb_wid][wb_rd] at the next clock edge; non-eop writebacks never clear bits.
REQ-005 Hazard: in_valid and any of bits [in_wid][in_rd], [in_wid][in_rs1], [in_wid][in_rs2], [in_wid][in_rs3] is effectively set.
REQ-006 Effective bit = registered bit AND NOT (same-cycle release of that warp/register); release bypass gives zero-cycle reuse.
REQ-007 Register index 0 is never set and never causes a hazard.
REQ-008 out_valid = in_valid && ~hazard; in_ready = out_ready && ~hazard; out_data = in_data; zero-cycle, combinational latency.
REQ-009 Set event: in_valid && in_ready && in_wb && in_rd != 0 sets bit [in_wid][in_rd] at the next edge.
REQ-010 Set and release of the same bit in the same cycle: set wins, bit ends set.
REQ-011 Set and release of different bits in the same cycle both take effect.
REQ-012 A release of an already-clear bit is a no-op.
REQ-013 Stall counter, width clog2(STALL_TIMEOUT+1): increments each cycle in_valid && hazard; resets to 0 on any cycle without that condition; saturates at STALL_TIMEOUT.
REQ-014 deadlock is set the cycle after the counter reaches STALL_TIMEOUT and stays set until reset.
REQ-015 No state depends on out_ready other than through in_ready; back-pressure without hazard never advances the stall counter.

Reset
REQ-016 During reset: all in-use bits cleared, stall counter 0, deadlock 0.
REQ-017 Reset mid-operation discards pending reservations; writebacks arriving after reset deassertion release clear bits only (no-op).
REQ-018 Combinational outputs (in_ready, out_valid, out_data) follow their equations during reset using the cleared state.

Structure
REQ-019 NW_BITS, NR_BITS, and NUM_REGS come from the shared VX_define header; no local redefinition.
REQ-020 No sub-module: the bitmap, hazard logic, and stall counter are inline; target 120-250 lines RTL.

Verification
REQ-021 Warp 1 issues rd=5, wb=1 -> next cycle, warp 1 rs1=5 stalls (in_ready=0); warp 2 rs1=5 issues immediately.
REQ-022 Bit [0][7] set; wb fire wid=0 rd=7 eop=1 in the same cycle as issue rs2=7 -> issue accepted that cycle (bypass).
REQ-023 Bit [0][7] set; wb fire wid=0 rd=7 eop=0 -> bit stays set, dependent still stalls; next fire with eop=1 clears it.
REQ-024 Same-cycle release of [0][3] plus issue wid=0 rd=3 wb=1 -> accepted; bit [0][3] set afterward.
REQ-025 in_rd=0, wb=1 issued twice back-to-back -> both accepted, no hazard.
REQ-026 STALL_TIMEOUT=8, hold hazard 9 cycles -> deadlock rises after counter hits 8, stays high after hazard clears, cleared only by reset.
